// File: rtl/cpu6502_bus_responder.sv
// Responder side of the 6502 memory bus: mirrored work RAM, side-loadable boot ROM
// and one peripheral page reached through a request/ack handshake that stalls the CPU.
module cpu6502_bus_responder #(
   parameter int unsigned RAM_ADDR_WIDTH = 11,
   parameter int unsigned ROM_ADDR_WIDTH = 13,
   parameter logic [7:0]  PERIPH_PAGE    = 8'h40,
   parameter int unsigned TIMEOUT        = 15
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clockEnable,
   input  logic [15:0]               cpuAddress,
   input  logic                      cpuWrite,
   input  logic [7:0]                cpuWriteData,
   output logic [7:0]                cpuReadData,
   output logic                      cpuReady,
   output logic                      periphRequest,
   output logic                      periphWrite,
   output logic [7:0]                periphAddress,
   output logic [7:0]                periphWriteData,
   input  logic [7:0]                periphReadData,
   input  logic                      periphAck,
   input  logic                      romLoadWrite,
   input  logic [ROM_ADDR_WIDTH-1:0] romLoadAddr,
   input  logic [7:0]                romLoadData,
   output logic                      busError
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [16:0] ROM_BASE = 17'(32'h0001_0000 - (32'd1 << ROM_ADDR_WIDTH));

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [7:0]                 rdata_q, rdata_d;
   logic                       ready_q, ready_d;
   logic                       req_q, req_d;
   logic                       pwrite_q, pwrite_d;
   logic [7:0]                 paddr_q, paddr_d;
   logic [7:0]                 pwdata_q, pwdata_d;
   logic                       err_q, err_d;

   logic [7:0]                 ram_q [0:(1 << RAM_ADDR_WIDTH)-1];
   logic [7:0]                 rom_q [0:(1 << ROM_ADDR_WIDTH)-1];

   logic                       accept_s;
   logic                       is_ram_s;
   logic                       is_periph_s;
   logic                       is_rom_s;
   logic                       ram_we_s;
   logic [RAM_ADDR_WIDTH-1:0]  ram_idx_s;
   logic [ROM_ADDR_WIDTH-1:0]  rom_idx_s;

   // RAM is decoded first so it wins over a peripheral page placed below 0x2000.
   assign accept_s    = clockEnable & ready_q & ~reset;
   assign is_ram_s    = (cpuAddress < 16'h2000);
   assign is_periph_s = (cpuAddress[15:8] == PERIPH_PAGE);
   assign is_rom_s    = ({1'b0, cpuAddress} >= ROM_BASE);
   assign ram_idx_s   = cpuAddress[RAM_ADDR_WIDTH-1:0];
   assign rom_idx_s   = cpuAddress[ROM_ADDR_WIDTH-1:0];
   assign ram_we_s    = accept_s & cpuWrite & is_ram_s & (state_q == ST_IDLE);

   // Memory arrays keep their contents across reset; the ROM load port ignores reset.
   always_ff @(posedge clock) begin
      if (ram_we_s) ram_q[ram_idx_s] <= cpuWriteData;
      if (romLoadWrite) rom_q[romLoadAddr] <= romLoadData;
   end

   // Next-state logic: bus decode in IDLE, handshake and timeout in WAIT.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      ready_d  = ready_q;
      req_d    = req_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (is_ram_s) begin
                  if (!cpuWrite) rdata_d = ram_q[ram_idx_s];
                  else           rdata_d = rdata_q;
               end else if (is_periph_s) begin
                  state_d  = ST_WAIT;
                  req_d    = 1'b1;
                  ready_d  = 1'b0;
                  pwrite_d = cpuWrite;
                  paddr_d  = cpuAddress[7:0];
                  pwdata_d = cpuWriteData;
                  cnt_d    = '0;
               end else if (is_rom_s) begin
                  if (!cpuWrite) rdata_d = rom_q[rom_idx_s];
                  else           rdata_d = rdata_q;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // An ack on the expiry edge still completes the access cleanly.
            if (periphAck) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               ready_d = 1'b1;
               if (!pwrite_q) rdata_d = periphReadData;
               else           rdata_d = rdata_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rdata_q  <= 8'h00;
         ready_q  <= 1'b1;
         req_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= 8'h00;
         pwdata_q <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         req_q    <= req_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         err_q    <= err_d;
      end
   end

   assign cpuReadData     = rdata_q;
   assign cpuReady        = ready_q;
   assign periphRequest   = req_q;
   assign periphWrite     = pwrite_q;
   assign periphAddress   = paddr_q;
   assign periphWriteData = pwdata_q;
   assign busError        = err_q;

endmodule

// File: doc/cpu6502_bus_responder.md
Name: cpu6502_bus_responder

Overview:
- Responder end of the 6502 CPU memory bus. It services each bus cycle the CPU core initiates (address, write strobe, write data) and returns read data.
- Contains internal work RAM (mirrored), boot ROM loadable over a side port, and one peripheral window reached through a request/acknowledge handshake. The peripheral path stalls the CPU via cpuReady.
- Sits between the 6502 core and the system's peripherals on the same clock and clockEnable.

Parameters:
- RAM_ADDR_WIDTH, 11: internal RAM is 2**RAM_ADDR_WIDTH bytes, mirrored across 0x0000-0x1FFF. Legal range 8..13.
- ROM_ADDR_WIDTH, 13: ROM is 2**ROM_ADDR_WIDTH bytes at the top of the address space. Base = 0x10000 - 2**ROM_ADDR_WIDTH.
- PERIPH_PAGE, 8'h40: high address byte of the 256-byte peripheral window.
- TIMEOUT, 15: maximum clocks to wait for periphAck before abandoning the access.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- clockEnable  in  1  CPU bus-cycle strobe; one access is evaluated per enabled clock
- cpuAddress  in  16  CPU address
- cpuWrite  in  1  1 = write cycle, 0 = read cycle
- cpuWriteData  in  8  CPU write data
- cpuReadData  out  8  registered read data returned to the CPU
- cpuReady  out  1  0 = stall; the CPU holds address, data and write unchanged
- periphRequest  out  1  peripheral access pending
- periphWrite  out  1  direction of the pending peripheral access
- periphAddress  out  8  low address byte of the peripheral access
- periphWriteData  out  8  peripheral write data
- periphReadData  in  8  peripheral read data, sampled with periphAck
- periphAck  in  1  single-cycle peripheral completion pulse
- romLoadWrite  in  1  ROM load strobe
- romLoadAddr  in  ROM_ADDR_WIDTH  ROM load address
- romLoadData  in  8  ROM load data
- busError  out  1  sticky flag: a peripheral access timed out

Behaviour:
- Reset state: cpuReadData=0x00, cpuReady=1, periphRequest=0, periphWrite=0, periphAddress=0, periphWriteData=0, busError=0, FSM=IDLE. RAM and ROM contents are preserved.

Access acceptance:
- An access is accepted on a clock edge where clockEnable=1, cpuReady=1 and reset=0.
- While cpuReady=0, clockEnable is ignored.

Address decode (priority order):
- RAM: cpuAddress < 0x2000. Index = cpuAddress[RAM_ADDR_WIDTH-1:0].
- PERIPH: cpuAddress[15:8] == PERIPH_PAGE.
- ROM: cpuAddress >= ROM base. Index = cpuAddress[ROM_ADDR_WIDTH-1:0].
- Otherwise the address is unmapped.

RAM and ROM timing:
- Read: cpuReadData is updated on the accepting edge, so it is valid in the cycle after acceptance. Latency is 1 clock.
- RAM write: stored on the accepting edge. cpuReadData is unchanged.
- ROM write by the CPU: ignored. cpuReadData is unchanged.

Unmapped and open-bus behaviour:
- Unmapped read: cpuReadData holds its previous value (open bus).
- Unmapped write: ignored.

ROM load port:
- When romLoadWrite=1, ROM[romLoadAddr] <= romLoadData on that edge. This works in any state and during reset.
- If it coincides with a CPU read of the same ROM byte, the read returns the old byte.

Peripheral FSM, state IDLE:
- An accepted PERIPH access moves the FSM to WAIT on that edge.
- On the same edge: periphRequest<=1, cpuReady<=0, periphWrite, periphAddress=cpuAddress[7:0] and periphWriteData are latched, and the timeout counter is cleared.

Peripheral FSM, state WAIT:
- Outputs hold stable while periphAck=0. The counter increments each clock.
- On periphAck=1:
  - periphRequest<=0, cpuReady<=1, FSM -> IDLE.
  - For a read, cpuReadData<=periphReadData. For a write, cpuReadData is unchanged.
- If the counter reaches TIMEOUT-1 with no ack:
  - Same exit as an ack, but cpuReadData is unchanged (open bus) and busError<=1.
  - An ack arriving on that same edge takes priority: no error is flagged.
- Minimum stall: the CPU sees cpuReady=0 for at least 1 clock.
- periphAck arriving while the FSM is in IDLE is ignored.

Other rules:
- busError clears only on reset.
- Reset during WAIT: the request is dropped immediately, all outputs return to reset values, and the peripheral must tolerate the abandoned request.
- clockEnable has no effect on the FSM once in WAIT. The FSM advances every clock.

Test Plan:
- RAM write/read with mirroring: write 0xA5 to 0x0012, then read 0x0812 and 0x1812 -> cpuReadData=0xA5 one clock after each read is accepted.
- ROM load and read: load 0x4C at romLoadAddr 0x1FFC, then CPU reads 0xFFFC -> 0x4C. CPU writes 0x00 to 0xFFFC, then reads again -> still 0x4C.
- Peripheral read: read 0x4007, peripheral pulses ack with data 0x3C three clocks after the request.
  - Required: periphRequest=1 with periphAddress=0x07 and periphWrite=0.
  - Required: cpuReady=0 for exactly 3 clocks, then cpuReady=1 and cpuReadData=0x3C. busError=0.
- Peripheral timeout: write 0x55 to 0x40FF with no ack.
  - Required: cpuReady is low for TIMEOUT (15) clocks, then high. periphRequest drops and busError=1.
  - A following RAM access completes normally.
- Open bus: read RAM returning 0x99, then read unmapped 0x8000 -> cpuReadData stays 0x99.
- Reset mid-WAIT: start a peripheral read, then assert reset on the second WAIT clock.
  - Required: the next clock shows periphRequest=0, cpuReady=1, cpuReadData=0x00, busError=0.
  - Previously written RAM data is still readable afterwards.
